sc_chain_loader: RTL

Configuration scan-chain controller for the FPGA fabric's configuration-memory scan chain (a serial string of scan-chain DFFs). It takes configuration words from a host over a valid/ready stream and serializes them into the chain head. It drives the chain shift enable and the chain clear. In verify mode it makes a second, recirculating pass that compares the chain tail against a re-streamed copy of the expected bits, leaving chain contents intact.

---
 rtl/sc_chain_loader_if.sv | 28 ++
 rtl/sc_chain_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/sc_chain_loader_if.sv
// sc_chain_loader_if: host word stream, scan-chain pins and session status of the chain loader.
interface sc_chain_loader_if #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W = 8
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    logic start;
    logic mode;
    logic in_valid;
    logic in_ready;
    logic [WORD_W-1:0] in_data;
    logic sc_head;
    logic sc_shift;
    logic sc_tail;
    logic sc_clear;
    logic busy;
    logic done;
    logic err;
    logic [CNT_W-1:0] bit_cnt;
    modport master (
        output start, mode, in_valid, in_data, sc_tail,
        input in_ready, sc_head, sc_shift, sc_clear, busy, done, err, bit_cnt
    );
    modport slave (
        input start, mode, in_valid, in_data, sc_tail,
        output in_ready, sc_head, sc_shift, sc_clear, busy, done, err, bit_cnt
    );
endinterface

// File: rtl/sc_chain_loader.sv
// sc_chain_loader: serialises host words into the configuration scan chain, with an optional recirculating verify pass.
module sc_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W = 8
) (
    input logic clk,
    input logic reset,
    sc_chain_loader_if.slave bus
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int LEFT_W = $clog2(WORD_W + 1);
    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, VERIFY} state_t;
    state_t state, state_n;
    logic mode_r, mode_n;
    logic err_r, err_n;
    logic [WORD_W-1:0] bits_r, bits_n;
    logic [LEFT_W-1:0] left_r, left_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic head_r, head_n;
    logic shift_r, shift_n;
    logic ready_r, ready_n;
    logic clear_r, busy_r, done_r, done_n;
    logic acc, last, miss, to_verify;
    int rem;
    assign acc = bus.in_valid && ready_r;
    assign last = shift_r && (cnt_r == CNT_W'(CHAIN_LEN - 1));
    assign miss = (state == VERIFY) && shift_r && (bus.sc_tail != head_r);
    assign to_verify = (state == LOAD) && mode_r;
    // head_r holds the bit in flight this cycle; bits_r/left_r hold what remains of the word
    always_comb begin
        state_n = state;
        mode_n = mode_r;
        err_n = err_r | miss;
        cnt_n = shift_r ? cnt_r + CNT_W'(1) : cnt_r;
        bits_n = bits_r;
        left_n = left_r;
        head_n = head_r;
        shift_n = 1'b0;
        done_n = 1'b0;
        rem = CHAIN_LEN - int'(cnt_r);
        case (state)
            IDLE: if (bus.start) begin
                state_n = CLEAR;
                mode_n = bus.mode;
                err_n = 1'b0;
                cnt_n = '0;
            end
            CLEAR: state_n = LOAD;
            default: begin
                if (left_r != '0) begin
                    shift_n = 1'b1;
                    head_n = bits_r[0];
                    bits_n = bits_r >> 1;
                    left_n = left_r - LEFT_W'(1);
                end else if (acc) begin
                    shift_n = 1'b1;
                    head_n = bus.in_data[0];
                    bits_n = bus.in_data >> 1;
                    // the last word of a pass only contributes the bits still missing from the chain
                    left_n = LEFT_W'((rem < WORD_W ? rem : WORD_W) - 1);
                end
                if (last) begin
                    state_n = to_verify ? VERIFY : IDLE;
                    done_n = !to_verify;
                    if (to_verify) cnt_n = '0;
                end
            end
        endcase
        ready_n = (state_n == LOAD || state_n == VERIFY) && !shift_n;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            mode_r <= 1'b0;
            err_r <= 1'b0;
            bits_r <= '0;
            left_r <= '0;
            cnt_r <= '0;
            head_r <= 1'b0;
            shift_r <= 1'b0;
            ready_r <= 1'b0;
            clear_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state <= state_n;
            mode_r <= mode_n;
            err_r <= err_n;
            bits_r <= bits_n;
            left_r <= left_n;
            cnt_r <= cnt_n;
            head_r <= head_n;
            shift_r <= shift_n;
            ready_r <= ready_n;
            clear_r <= state_n == CLEAR;
            busy_r <= state_n != IDLE;
            done_r <= done_n;
        end
    end
    // in VERIFY the tail feeds straight back into the head so the chain content survives the pass
    assign bus.sc_head = (state == VERIFY) ? bus.sc_tail : head_r;
    assign bus.in_ready = ready_r;
    assign bus.sc_shift = shift_r;
    assign bus.sc_clear = clear_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err = err_r | miss;
    assign bus.bit_cnt = cnt_r;
endmodule
